// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//
// Fetch-side branch predictor and resolution sink for the execute stage.
// A direct-mapped BTB (valid, tag, target, 2-bit saturating counter per
// entry) is looked up combinationally with the fetch PC to produce a
// predicted next PC. Resolved branches from execute are checked against
// what was predicted at fetch. Wrong guesses raise mispredict with the
// correct redirect PC, and every resolved branch trains the table.
// All state changes on the falling edge of clk, matching the pipeline
// registers.
//
// Ports:
//   clk                       pipeline clock (state updates on falling edge)
//   rst                       asynchronous, active-low reset
//   fetchPc                   PC being fetched
//   predValid                 BTB hit for fetchPc
//   predTaken                 hit and counter predicts taken
//   predNextPc                predicted next fetch PC
//   stall                     resolution inputs are ignored while high
//   exIsBranch                execute stage holds a branch or jump
//   exBranchTaken             resolved direction
//   exIsBranchTakenPredicted  direction predicted at fetch
//   exIsNextPcPredicted       a target was predicted at fetch
//   exPredictedNextPc         PC predicted at fetch
//   exIrregPc                 resolved taken target
//   exPc                      PC of the resolving instruction
//   mispredict                resolving branch was mispredicted
//   redirectPc                correct next PC (0 unless mispredict)
//   branchCount               saturating count of resolved branches
//   missCount                 saturating count of mispredicts
//
// Resolution handshake: a branch is consumed in exactly the cycles where
// rst && exIsBranch && !stall holds at the falling clock edge. There is no
// back-pressure toward execute, and stall simply makes the offer invisible.

module branch_predict_unit #(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetchPc,
    output logic        predValid,
    output logic        predTaken,
    output logic [31:0] predNextPc,
    input  logic        stall,
    input  logic        exIsBranch,
    input  logic        exBranchTaken,
    input  logic        exIsBranchTakenPredicted,
    input  logic        exIsNextPcPredicted,
    input  logic [31:0] exPredictedNextPc,
    input  logic [31:0] exIrregPc,
    input  logic [31:0] exPc,
    output logic        mispredict,
    output logic [31:0] redirectPc,
    output logic [31:0] branchCount,
    output logic [31:0] missCount
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      branch_count_q;
    logic [31:0]      miss_count_q;

    // Fetch-side lookup
    logic [IDX-1:0]   f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = fetchPc[IDX+1:2];
    assign f_tag = fetchPc[31:IDX+2];
    // Gating with rst keeps the outputs at reset values for the whole
    // reset window, independent of when the array clear lands.
    assign f_hit = rst && valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    always_comb begin
        predValid  = f_hit;
        predTaken  = f_hit && ctr_q[f_idx][1];
        predNextPc = fetchPc + 32'd4;
        if (predTaken) begin
            predNextPc = target_q[f_idx];
        end
    end

    // Execute-side resolution
    logic [IDX-1:0]   e_idx;
    logic [TAG_W-1:0] e_tag;
    logic             e_hit;
    logic [1:0]       e_ctr;
    logic             resolve;
    logic             dir_wrong;
    logic             target_wrong;

    assign e_idx   = exPc[IDX+1:2];
    assign e_tag   = exPc[31:IDX+2];
    assign e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign e_ctr   = ctr_q[e_idx];
    assign resolve = rst && exIsBranch && !stall;

    // A taken branch is also wrong when fetch had no target or the wrong one.
    assign dir_wrong    = exBranchTaken != exIsBranchTakenPredicted;
    assign target_wrong = exBranchTaken &&
                          (!exIsNextPcPredicted || (exPredictedNextPc != exIrregPc));

    always_comb begin
        mispredict = resolve && (dir_wrong || target_wrong);
        redirectPc = 32'd0;
        if (mispredict) begin
            redirectPc = exBranchTaken ? exIrregPc : exPc + 32'd4;
        end
    end

    // Training and statistics
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else if (resolve) begin
            if (e_hit) begin
                if (exBranchTaken) begin
                    if (e_ctr != 2'b11) begin
                        ctr_q[e_idx] <= e_ctr + 2'd1;
                    end
                    target_q[e_idx] <= exIrregPc;
                end else if (e_ctr != 2'b00) begin
                    ctr_q[e_idx] <= e_ctr - 2'd1;
                end
            end else if (exBranchTaken) begin
                // Taken miss replaces whatever occupies the slot, starting
                // weakly taken so the next fetch follows the new target.
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= exIrregPc;
                ctr_q[e_idx]    <= 2'b10;
            end
            if (branch_count_q != 32'hFFFF_FFFF) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if (mispredict && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign branchCount = branch_count_q;
    assign missCount   = miss_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit: directed vector table, hand-written
// corner sequences (same-cycle lookup/training, asynchronous reset) and a
// randomized phase checked against a behavioural table model.

module tb_branch_predict_unit;

    localparam int ENTRIES = 64;
    localparam int IDX     = $clog2(ENTRIES);

    // Clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] fetchPc = '0;
    logic        predValid, predTaken;
    logic [31:0] predNextPc;
    logic        stall = 1'b0;
    logic        exIsBranch = 1'b0;
    logic        exBranchTaken = 1'b0;
    logic        exIsBranchTakenPredicted = 1'b0;
    logic        exIsNextPcPredicted = 1'b0;
    logic [31:0] exPredictedNextPc = '0;
    logic [31:0] exIrregPc = '0;
    logic [31:0] exPc = '0;
    logic        mispredict;
    logic [31:0] redirectPc;
    logic [31:0] branchCount, missCount;

    branch_predict_unit #(.ENTRIES(ENTRIES)) dut (
        .clk(clk),
        .rst(rst),
        .fetchPc(fetchPc),
        .predValid(predValid),
        .predTaken(predTaken),
        .predNextPc(predNextPc),
        .stall(stall),
        .exIsBranch(exIsBranch),
        .exBranchTaken(exBranchTaken),
        .exIsBranchTakenPredicted(exIsBranchTakenPredicted),
        .exIsNextPcPredicted(exIsNextPcPredicted),
        .exPredictedNextPc(exPredictedNextPc),
        .exIrregPc(exIrregPc),
        .exPc(exPc),
        .mispredict(mispredict),
        .redirectPc(redirectPc),
        .branchCount(branchCount),
        .missCount(missCount)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver
    task automatic drive(input logic st, input logic br, input logic tk, input logic pt,
                         input logic np, input logic [31:0] pnpc, input logic [31:0] irreg,
                         input logic [31:0] expc, input logic [31:0] fpc);
        stall                    = st;
        exIsBranch               = br;
        exBranchTaken            = tk;
        exIsBranchTakenPredicted = pt;
        exIsNextPcPredicted      = np;
        exPredictedNextPc        = pnpc;
        exIrregPc                = irreg;
        exPc                     = expc;
        fetchPc                  = fpc;
    endtask

    // Directed vector table
    typedef struct {
        logic        st, br, tk, pt, np;
        logic [31:0] pnpc, irreg, expc, fpc;
        logic        exp_misp;
        logic [31:0] exp_redir;
        logic        exp_pv, exp_pt;
        logic [31:0] exp_pn, exp_bc, exp_mc;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic br, input logic tk, input logic pt,
                                input logic np, input logic [31:0] pnpc, input logic [31:0] irreg,
                                input logic [31:0] expc, input logic [31:0] fpc,
                                input logic em, input logic [31:0] er,
                                input logic epv, input logic ept, input logic [31:0] epn,
                                input logic [31:0] ebc, input logic [31:0] emc);
        vec_t v;
        v.st = st; v.br = br; v.tk = tk; v.pt = pt; v.np = np;
        v.pnpc = pnpc; v.irreg = irreg; v.expc = expc; v.fpc = fpc;
        v.exp_misp = em; v.exp_redir = er;
        v.exp_pv = epv; v.exp_pt = ept; v.exp_pn = epn;
        v.exp_bc = ebc; v.exp_mc = emc;
        return v;
    endfunction

    vec_t vecs[18];

    // Behavioural reference model
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    longint      m_bc, m_mc;
    logic [32:0] exp_q[$];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic m_lookup(input logic [31:0] pc, output logic hit, output logic tk,
                            output logic [31:0] nxt);
        int i = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && (m_ctr[i] >= 2);
        nxt = tk ? m_target[i] : pc + 32'd4;
    endtask

    // Outcome of the current resolution inputs: {mispredict, redirect}.
    function automatic logic [32:0] m_outcome();
        logic wrong;
        logic [31:0] correct;
        if (!exIsBranch || stall) return 33'd0;
        correct = exBranchTaken ? exIrregPc : exPc + 32'd4;
        if (exBranchTaken != exIsBranchTakenPredicted) wrong = 1;
        else if (!exBranchTaken) wrong = 0;
        else wrong = !(exIsNextPcPredicted && exPredictedNextPc == exIrregPc);
        return wrong ? {1'b1, correct} : 33'd0;
    endfunction

    task automatic m_train(input logic wrong);
        int i;
        if (!exIsBranch || stall) return;
        i = idx_of(exPc);
        if (m_valid[i] && m_tag[i] == tag_of(exPc)) begin
            if (exBranchTaken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = exIrregPc;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (exBranchTaken) begin
            m_valid[i] = 1; m_tag[i] = tag_of(exPc); m_target[i] = exIrregPc; m_ctr[i] = 2;
        end
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (wrong && m_mc < 64'hFFFF_FFFF) m_mc++;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base = $urandom_range(0, 1) ? 32'hABC0_0000 : 32'h0;
        return base + 32'($urandom_range(0, 3) * 256) + 32'($urandom_range(0, 3) * 4);
    endfunction

    initial begin
        // Table contents:  st br tk pt np pnpc irreg expc fpc | misp redir | pv pt pn bc mc
        vecs[0]  = mk(0,0,0,0,0, 0,      0,      0,      32'h100, 0, 0,      0,0,32'h104, 0, 0);
        vecs[1]  = mk(0,1,1,0,0, 0,      32'h200,32'h100,32'h100, 1,32'h200,1,1,32'h200, 1, 1);
        vecs[2]  = mk(0,1,1,1,1,32'h200,32'h200,32'h100,32'h100, 0, 0,      1,1,32'h200, 2, 1);
        vecs[3]  = mk(0,1,1,1,1,32'h200,32'h200,32'h100,32'h100, 0, 0,      1,1,32'h200, 3, 1);
        vecs[4]  = mk(0,1,1,1,1,32'h200,32'h200,32'h100,32'h100, 0, 0,      1,1,32'h200, 4, 1);
        vecs[5]  = mk(0,1,0,1,1,32'h200,32'h200,32'h100,32'h100, 1,32'h104,1,1,32'h200, 5, 2);
        vecs[6]  = mk(0,1,1,1,1,32'h200,32'h300,32'h100,32'h100, 1,32'h300,1,1,32'h300, 6, 3);
        vecs[7]  = mk(1,1,1,0,0, 0,      32'h500,32'h100,32'h100, 0, 0,      1,1,32'h300, 6, 3);
        vecs[8]  = mk(0,1,1,0,0, 0,      32'h400,32'h200,32'h100, 1,32'h400,0,0,32'h104, 7, 4);
        vecs[9]  = mk(0,0,0,0,0, 0,      0,      0,      32'h200, 0, 0,      1,1,32'h400, 7, 4);
        vecs[10] = mk(0,1,0,0,0, 0,      0,      32'h104,32'h104, 0, 0,      0,0,32'h108, 8, 4);
        vecs[11] = mk(0,1,1,1,0,32'h40, 32'h40, 32'h108,32'h108, 1,32'h40, 1,1,32'h40,  9, 5);
        vecs[12] = mk(0,1,0,0,0, 0,      0,      32'h108,32'h108, 0, 0,      1,0,32'h10C,10, 5);
        vecs[13] = mk(0,1,0,0,0, 0,      0,      32'h108,32'h108, 0, 0,      1,0,32'h10C,11, 5);
        vecs[14] = mk(0,1,0,0,0, 0,      0,      32'h108,32'h108, 0, 0,      1,0,32'h10C,12, 5);
        vecs[15] = mk(0,1,1,0,0, 0,      32'h40, 32'h108,32'h108, 1,32'h40, 1,0,32'h10C,13, 6);
        vecs[16] = mk(0,1,1,0,0, 0,      32'h40, 32'h108,32'h108, 1,32'h40, 1,1,32'h40, 14, 7);
        vecs[17] = mk(0,0,0,0,0, 0,      0,      0,32'hFFFF_FFFC, 0, 0,      0,0,32'h0,   14, 7);

        // Reset, with a mispredicting branch offered to prove it is ignored
        #2 rst = 1'b0;
        drive(0, 1, 1, 0, 0, 0, 32'h200, 32'h100, 32'h100);
        repeat (2) @(posedge clk);
        #1;
        check("reset_pred_valid", 32'(predValid), 0);
        check("reset_pred_next", predNextPc, 32'h104);
        check("reset_mispredict", 32'(mispredict), 0);
        check("reset_redirect", redirectPc, 0);
        check("reset_branch_count", branchCount, 0);
        check("reset_miss_count", missCount, 0);
        @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            drive(vecs[i].st, vecs[i].br, vecs[i].tk, vecs[i].pt, vecs[i].np,
                  vecs[i].pnpc, vecs[i].irreg, vecs[i].expc, vecs[i].fpc);
            #1;
            check($sformatf("vec%0d_mispredict", i), 32'(mispredict), 32'(vecs[i].exp_misp));
            check($sformatf("vec%0d_redirect", i), redirectPc, vecs[i].exp_redir);
            @(negedge clk);
            #1;
            check($sformatf("vec%0d_pred_valid", i), 32'(predValid), 32'(vecs[i].exp_pv));
            check($sformatf("vec%0d_pred_taken", i), 32'(predTaken), 32'(vecs[i].exp_pt));
            check($sformatf("vec%0d_pred_next", i), predNextPc, vecs[i].exp_pn);
            check($sformatf("vec%0d_branch_count", i), branchCount, vecs[i].exp_bc);
            check($sformatf("vec%0d_miss_count", i), missCount, vecs[i].exp_mc);
        end

        // Same-index lookup and training in one cycle sees the old entry
        @(posedge clk);
        drive(0, 1, 1, 0, 0, 0, 32'h600, 32'h300, 32'h300);
        #1;
        check("same_cycle_pred_valid", 32'(predValid), 0);
        check("same_cycle_pred_next", predNextPc, 32'h304);
        check("same_cycle_redirect", redirectPc, 32'h600);
        @(negedge clk);
        #1;
        check("after_train_pred_valid", 32'(predValid), 1);
        check("after_train_pred_next", predNextPc, 32'h600);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        drive(0, 1, 1, 0, 0, 0, 32'h700, 32'h100, 32'h300);
        #1;
        check("pre_reset_mispredict", 32'(mispredict), 1);
        check("pre_reset_pred_next", predNextPc, 32'h600);
        #2 rst = 1'b0;
        #1;
        check("async_pred_valid", 32'(predValid), 0);
        check("async_pred_taken", 32'(predTaken), 0);
        check("async_pred_next", predNextPc, 32'h304);
        check("async_mispredict", 32'(mispredict), 0);
        check("async_redirect", redirectPc, 0);
        check("async_branch_count", branchCount, 0);
        check("async_miss_count", missCount, 0);
        @(negedge clk);
        #1;
        check("in_reset_no_train", branchCount, 0);
        @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h300);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_pred_valid", 32'(predValid), 0);

        // Randomized phase against the model
        m_reset();
        for (int n = 0; n < 400; n++) begin
            logic        h, t;
            logic [31:0] nx;
            logic [32:0] e;
            @(posedge clk);
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  0, 32'($urandom_range(0, 255) * 4), rand_pc(), rand_pc());
            exPredictedNextPc = $urandom_range(0, 1) ? exIrregPc : 32'($urandom_range(0, 255) * 4);
            m_lookup(fetchPc, h, t, nx);
            exp_q.push_back(m_outcome());
            #1;
            check("rnd_pred_valid", 32'(predValid), 32'(h));
            check("rnd_pred_taken", 32'(predTaken), 32'(t));
            check("rnd_pred_next", predNextPc, nx);
            e = exp_q.pop_front();
            check("rnd_mispredict", 32'(mispredict), 32'(e[32]));
            check("rnd_redirect", redirectPc, e[31:0]);
            @(negedge clk);
            m_train(e[32]);
            #1;
            check("rnd_branch_count", branchCount, m_bc[31:0]);
            check("rnd_miss_count", missCount, m_mc[31:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Fetch-side branch predictor and the resolution sink for the execute stage's branch outcome port. Combinationally supplies a predicted next PC for the fetch PC, receives resolved branch information from the execute stage, flags mispredictions with a redirect PC, and trains a direct-mapped BTB with 2-bit saturating counters. It sits between the execute stage's branch outputs and the fetch stage's PC selection.

## Interface
- ENTRIES, 64: number of BTB/counter entries; power of two, 4..1024. IDX = log2(ENTRIES).
- clk  in  1  pipeline clock; all state updates on falling edge, matching the pipeline registers.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- fetchPc  in  32  PC currently being fetched.
- predValid  out  1  BTB hit for fetchPc.
- predTaken  out  1  predicted taken for fetchPc.
- predNextPc  out  32  predicted next fetch PC.
- stall  in  1  structure stall; resolution inputs are ignored while high.
- exIsBranch  in  1  execute stage holds a branch or jump.
- exBranchTaken  in  1  resolved direction.
- exIsBranchTakenPredicted  in  1  direction predicted at fetch.
- exIsNextPcPredicted  in  1  a target was predicted at fetch.
- exPredictedNextPc  in  32  PC predicted at fetch.
- exIrregPc  in  32  resolved taken target.
- exPc  in  32  PC of the resolving instruction.
- mispredict  out  1  resolving branch was mispredicted.
- redirectPc  out  32  correct next PC when mispredict is high.
- branchCount  out  32  resolved-branch counter.
- missCount  out  32  mispredict counter.

## Operation
- Index = pc[IDX+1:2]; tag = pc[31:IDX+2]. Entry = {valid, tag, target[31:0], ctr[1:0]}.
- Lookup (fetchPc): hit = valid && tag match. predValid = hit; predTaken = hit && ctr[1]; predNextPc = predTaken ? target : fetchPc+4 (mod 2^32).
- Resolve event R = rst && exIsBranch && !stall.
- mispredict = R && ((exBranchTaken != exIsBranchTakenPredicted) || (exBranchTaken && (!exIsNextPcPredicted || exPredictedNextPc != exIrregPc))). Otherwise 0.
- redirectPc = exBranchTaken ? exIrregPc : exPc+4; driven 0 when mispredict is 0.
- Training on R (lookup of exPc in the table):
  - hit: ctr saturating +1 if taken (max 2'b11), −1 if not (min 2'b00); if taken, target <= exIrregPc.
  - miss, taken: allocate/overwrite entry: valid=1, tag, target=exIrregPc, ctr=2'b10.
  - miss, not taken: no change.
- branchCount +1 on every R; missCount +1 on every mispredict; both saturate at 32'hFFFF_FFFF.
- Reset: all valid=0, ctr=2'b01, tag/target=0, both counters=0. Outputs during reset: predValid=0, predTaken=0, predNextPc=fetchPc+4, mispredict=0, redirectPc=0.

## Timing
- Lookup, mispredict, redirectPc: combinational, 0-cycle latency.
- Table and counter updates on the falling edge of clk in which R is sampled high; visible to lookup immediately after that edge.
- Same-index lookup and training in one cycle: lookup returns the pre-update entry.
- stall high: no training, no count, mispredict=0, irrespective of other inputs.
- rst asserted mid-operation: tables and counters clear at once (asynchronous), independent of clk; first training possible on the first falling edge with rst high.
- Aliasing: differing tag at same index on taken resolution replaces the entry; no replacement on not-taken.

## Test plan
- Reset then fetchPc=0x100 -> predValid=0, predTaken=0, predNextPc=0x104; counters=0.
- Resolve exPc=0x100 taken, exIrregPc=0x200, predicted not-taken -> mispredict=1, redirectPc=0x200; next cycle fetchPc=0x100 gives predTaken=1, predNextPc=0x200, missCount=1, branchCount=1.
- Train 0x100 taken 3 more times then not-taken once -> ctr 10→11 (saturate)→10; predTaken stays 1; not-taken with predicted taken gives mispredict=1, redirectPc=0x104.
- Predicted taken with exPredictedNextPc=0x200, exIrregPc=0x300 -> mispredict=1, redirectPc=0x300; entry target becomes 0x300.
- stall=1 with a taken mispredicted branch -> mispredict=0, no table or counter change.
- Alias: ENTRIES=64, train 0x100 taken, then 0x200 (same index) taken to 0x400 -> fetchPc=0x100 misses, fetchPc=0x200 predicts 0x400; assert rst=0 mid-cycle -> all outputs at reset values immediately.
